sdram_access_unit: RTL and testbench

//  Datapath partner of the control unit. Holds the i/j/i_wr pixel counters and their rollover flags.

---
 rtl/sdram_access_unit_pkg.sv | 24 ++
 rtl/sdram_access_unit_idx_counter.sv | 26 ++
 rtl/sdram_access_unit.sv | 205 ++++++++++++++++++++
 tb/tb_sdram_access_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_access_unit_pkg.sv
// Shared image geometry, SDRAM access FSM encoding and width helper
// for the SDRAM access datapath.
package sdram_access_unit_pkg;

  localparam int unsigned IMG_W_DEF    = 640;
  localparam int unsigned IMG_H_DEF    = 480;
  localparam int unsigned ADDR_W_DEF   = 24;
  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned IN_BASE_DEF  = 0;
  localparam int unsigned OUT_BASE_DEF = IMG_W_DEF * IMG_H_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    WR_REQ  = 2'd2,
    RD_DONE = 2'd3
  } sdram_state_t;

  // Bits needed to hold 0..max (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned max);
    return (max > 0) ? $clog2(max + 1) : 1;
  endfunction

endpackage

// File: rtl/sdram_access_unit_idx_counter.sv
// Pixel index counter: counts 0..MAX on en, wraps to 0 when enabled at MAX.
module idx_counter
  import sdram_access_unit_pkg::*;
#(
  parameter int unsigned MAX = 1,
  localparam int unsigned W  = cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         rollover
);

  assign rollover = (count == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= rollover ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/sdram_access_unit.sv
// Pixel counters, SDRAM address generation and request/ack handshake
// with the SDRAM controller on behalf of the control unit.
module sdram_access_unit
  import sdram_access_unit_pkg::*;
#(
  parameter int unsigned IMG_W    = IMG_W_DEF,
  parameter int unsigned IMG_H    = IMG_H_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned IN_BASE  = IN_BASE_DEF,
  parameter int unsigned OUT_BASE = IMG_W * IMG_H
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_flag,
  input  logic              enable_i,
  input  logic              enable_j,
  input  logic              enable_i_wr,
  input  logic              enable_addr_calc_sdram,
  input  logic              mode_addr_calc_sdram,
  input  logic              read_en_sdram,
  input  logic              write_en_sdram,
  input  logic [DATA_W-1:0] wr_pixel,
  output logic              rollover_i,
  output logic              rollover_j,
  output logic              rollover_i_wr,
  output logic              dataRead_sdram,
  output logic [DATA_W-1:0] rd_pixel,
  output logic              wr_done,
  output logic              busy,
  output logic              overrun_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned I_W  = cnt_w(IMG_W - 1);
  localparam int unsigned J_W  = cnt_w(IMG_H - 2);
  localparam int unsigned IW_W = cnt_w(IMG_W - 2);

  logic [I_W-1:0]  i_cnt;
  logic [J_W-1:0]  j_cnt;
  logic [IW_W-1:0] i_wr_cnt;

  idx_counter #(.MAX(IMG_W - 1)) u_cnt_i (
    .clk      (clk),
    .rst      (rst),
    .en       (enable_i),
    .clr      (start_flag),
    .count    (i_cnt),
    .rollover (rollover_i)
  );

  idx_counter #(.MAX(IMG_H - 2)) u_cnt_j (
    .clk      (clk),
    .rst      (rst),
    .en       (enable_j),
    .clr      (start_flag),
    .count    (j_cnt),
    .rollover (rollover_j)
  );

  idx_counter #(.MAX(IMG_W - 2)) u_cnt_i_wr (
    .clk      (clk),
    .rst      (rst),
    .en       (enable_i_wr),
    .clr      (start_flag),
    .count    (i_wr_cnt),
    .rollover (rollover_i_wr)
  );

  // Address arithmetic, all at ADDR_W width.
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [ADDR_W-1:0] wr_addr_c;

  assign rd_addr_c = ADDR_W'(IN_BASE)
                   + (ADDR_W'(j_cnt) + ADDR_W'(mode_addr_calc_sdram)) * ADDR_W'(IMG_W)
                   + ADDR_W'(i_cnt);
  assign wr_addr_c = ADDR_W'(OUT_BASE)
                   + ADDR_W'(j_cnt) * ADDR_W'(IMG_W - 1)
                   + ADDR_W'(i_wr_cnt);

  always_ff @(posedge clk) begin
    if (rst || start_flag) begin
      rd_addr <= '0;
    end else if (enable_addr_calc_sdram) begin
      rd_addr <= rd_addr_c;
    end
  end

  sdram_state_t      state_q;
  sdram_state_t      state_d;
  logic              mem_req_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [DATA_W-1:0] rd_pixel_d;
  logic              data_read_d;
  logic              wr_done_d;
  logic              busy_d;
  logic              overrun_d;
  logic              any_req;

  assign any_req = read_en_sdram || write_en_sdram;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      rd_pixel       <= '0;
      dataRead_sdram <= 1'b0;
      wr_done        <= 1'b0;
      busy           <= 1'b0;
      overrun_err    <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_req        <= mem_req_d;
      mem_we         <= mem_we_d;
      mem_addr       <= mem_addr_d;
      mem_wdata      <= mem_wdata_d;
      rd_pixel       <= rd_pixel_d;
      dataRead_sdram <= data_read_d;
      wr_done        <= wr_done_d;
      busy           <= busy_d;
      overrun_err    <= overrun_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (read_en_sdram) begin
          state_d = RD_REQ;
        end else if (write_en_sdram) begin
          state_d = WR_REQ;
        end
      end
      RD_REQ:  if (mem_ack) state_d = RD_DONE;
      WR_REQ:  if (mem_ack) state_d = IDLE;
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; read wins a same-cycle collision.
  always_comb begin
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rd_pixel_d  = rd_pixel;
    data_read_d = 1'b0;
    wr_done_d   = 1'b0;
    busy_d      = (state_d != IDLE);
    overrun_d   = overrun_err;
    case (state_q)
      IDLE: begin
        if (read_en_sdram) begin
          mem_req_d  = 1'b1;
          mem_addr_d = rd_addr;
          if (write_en_sdram) overrun_d = 1'b1;
        end else if (write_en_sdram) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_addr_c;
          mem_wdata_d = wr_pixel;
        end
      end
      RD_REQ: begin
        if (mem_ack) begin
          rd_pixel_d = mem_rdata;
        end else begin
          mem_req_d = 1'b1;
        end
        if (any_req) overrun_d = 1'b1;
      end
      WR_REQ: begin
        if (mem_ack) begin
          wr_done_d = 1'b1;
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = 1'b1;
        end
        if (any_req) overrun_d = 1'b1;
      end
      RD_DONE: begin
        data_read_d = 1'b1;
        if (any_req) overrun_d = 1'b1;
      end
      default: ;
    endcase
    if (start_flag) overrun_d = 1'b0;
  end

endmodule

// File: tb/tb_sdram_access_unit.sv
// Bench for sdram_access_unit on a 4x3 image with the output image at 16.
module tb_sdram_access_unit;

  localparam int IMG_W    = 4;
  localparam int IMG_H    = 3;
  localparam int ADDR_W   = 24;
  localparam int DATA_W   = 8;
  localparam int IN_BASE  = 0;
  localparam int OUT_BASE = 16;

  logic              clk = 1'b0;
  logic              rst, start_flag, enable_i, enable_j, enable_i_wr;
  logic              enable_addr_calc_sdram, mode_addr_calc_sdram;
  logic              read_en_sdram, write_en_sdram, mem_ack;
  logic [DATA_W-1:0] wr_pixel, mem_rdata, rd_pixel, mem_wdata;
  logic              rollover_i, rollover_j, rollover_i_wr;
  logic              dataRead_sdram, wr_done, busy, overrun_err, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;

  int tests = 0;
  int fails = 0;
  int mi = 0, mj = 0, mw = 0;

  always #5 clk = ~clk;

  sdram_access_unit #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE)
  ) dut (
    .clk(clk), .rst(rst), .start_flag(start_flag),
    .enable_i(enable_i), .enable_j(enable_j), .enable_i_wr(enable_i_wr),
    .enable_addr_calc_sdram(enable_addr_calc_sdram),
    .mode_addr_calc_sdram(mode_addr_calc_sdram),
    .read_en_sdram(read_en_sdram), .write_en_sdram(write_en_sdram),
    .wr_pixel(wr_pixel),
    .rollover_i(rollover_i), .rollover_j(rollover_j), .rollover_i_wr(rollover_i_wr),
    .dataRead_sdram(dataRead_sdram), .rd_pixel(rd_pixel), .wr_done(wr_done),
    .busy(busy), .overrun_err(overrun_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic       ei;
    logic       ej;
    logic       ew;
    logic [2:0] exp_rol;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference counters: plain modular arithmetic over each index range.
  task automatic model_step(input logic ei, input logic ej, input logic ew);
    if (ei) mi = (mi + 1) % IMG_W;
    if (ej) mj = (mj + 1) % (IMG_H - 1);
    if (ew) mw = (mw + 1) % (IMG_W - 1);
  endtask

  task automatic model_clear();
    mi = 0; mj = 0; mw = 0;
  endtask

  task automatic check_rol(input string name);
    logic [2:0] exp;
    exp = {mi == IMG_W - 1, mj == IMG_H - 2, mw == IMG_W - 2};
    check(name, 32'({rollover_i, rollover_j, rollover_i_wr}), 32'(exp));
  endtask

  task automatic pulse(input logic ei, input logic ej, input logic ew);
    enable_i = ei; enable_j = ej; enable_i_wr = ew;
    tick();
    enable_i = 1'b0; enable_j = 1'b0; enable_i_wr = 1'b0;
    model_step(ei, ej, ew);
  endtask

  task automatic do_start();
    start_flag = 1'b1;
    tick();
    start_flag = 1'b0;
    model_clear();
  endtask

  task automatic addr_calc(input logic mode);
    mode_addr_calc_sdram = mode;
    enable_addr_calc_sdram = 1'b1;
    tick();
    enable_addr_calc_sdram = 1'b0;
    mode_addr_calc_sdram = 1'b0;
  endtask

  // One randomized read or write transaction against the reference model.
  task automatic rand_txn();
    int          n;
    logic        mode;
    logic [31:0] exp_addr;
    logic [7:0]  data;
    logic        is_rd;
    n = $urandom_range(0, 5);
    for (int k = 0; k < n; k++) begin
      pulse(1'($urandom), 1'($urandom), 1'($urandom));
      check_rol("rand_rollover");
    end
    is_rd = 1'($urandom);
    data  = 8'($urandom);
    if (is_rd) begin
      mode = 1'($urandom);
      exp_addr = 32'(IN_BASE + (mj + int'(mode)) * IMG_W + mi);
      addr_calc(mode);
      read_en_sdram = 1'b1;
    end else begin
      exp_addr = 32'(OUT_BASE + mj * (IMG_W - 1) + mw);
      wr_pixel = data;
      write_en_sdram = 1'b1;
    end
    tick();
    read_en_sdram = 1'b0; write_en_sdram = 1'b0;
    check("rand_req", 32'({mem_req, mem_we, busy}), 32'({1'b1, !is_rd, 1'b1}));
    check("rand_addr", 32'(mem_addr), exp_addr);
    if (!is_rd) check("rand_wdata", 32'(mem_wdata), 32'(data));
    n = $urandom_range(0, 3);
    for (int k = 0; k < n; k++) begin
      pulse(1'($urandom), 1'($urandom), 1'($urandom));
      check_rol("rand_wait_rollover");
      check("rand_addr_hold", 32'({mem_req, mem_addr}), 32'({1'b1, exp_addr[ADDR_W-1:0]}));
    end
    mem_ack = 1'b1;
    mem_rdata = data;
    tick();
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    if (is_rd) begin
      check("rand_rd_wait", 32'({mem_req, dataRead_sdram}), 32'(0));
      tick();
      check("rand_rd_done", 32'({dataRead_sdram, rd_pixel}), 32'({1'b1, data}));
    end else begin
      check("rand_wr_done", 32'({wr_done, mem_req, busy}), 32'(3'b100));
    end
  endtask

  initial begin
    rst = 1'b1; start_flag = 1'b0; enable_i = 1'b0; enable_j = 1'b0; enable_i_wr = 1'b0;
    enable_addr_calc_sdram = 1'b0; mode_addr_calc_sdram = 1'b0;
    read_en_sdram = 1'b0; write_en_sdram = 1'b0; wr_pixel = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b000};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'b000};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'b100};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 3'b000};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 3'b010};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 3'b000};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 3'b000};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 3'b001};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 3'b000};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 3'b010};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 3'b011};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 3'b100};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 3'b100};

    tick(); tick();
    rst = 1'b0;
    check("reset_outputs",
          32'({mem_req, mem_we, busy, overrun_err, dataRead_sdram, wr_done}), 32'(0));
    check("reset_rollover", 32'({rollover_i, rollover_j, rollover_i_wr}), 32'(0));
    check("reset_data", 32'({mem_addr, rd_pixel}), 32'(0));

    // Counter wrap table.
    for (int v = 0; v < 13; v++) begin
      pulse(vecs[v].ei, vecs[v].ej, vecs[v].ew);
      check($sformatf("wrap_vec%0d", v),
            32'({rollover_i, rollover_j, rollover_i_wr}), 32'(vecs[v].exp_rol));
    end

    // Read with five wait cycles, counters moving underneath.
    do_start();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    addr_calc(1'b1);
    read_en_sdram = 1'b1;
    tick();
    read_en_sdram = 1'b0;
    check("rd_req", 32'({mem_req, mem_we, busy}), 32'(3'b101));
    check("rd_addr", 32'(mem_addr), 32'd10);
    for (int k = 0; k < 5; k++) begin
      pulse(1'b1, 1'b0, 1'b0);
      check("rd_hold", 32'({mem_req, mem_addr}), 32'({1'b1, 24'd10}));
    end
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    check("rd_after_ack", 32'({mem_req, dataRead_sdram, busy}), 32'(3'b001));
    tick();
    check("rd_pulse", 32'({dataRead_sdram, rd_pixel, busy}), 32'({1'b1, 8'h3C, 1'b0}));
    tick();
    check("rd_pulse_end", 32'({dataRead_sdram, rd_pixel}), 32'({1'b0, 8'h3C}));

    // Write at j=1, i_wr=1.
    do_start();
    pulse(1'b0, 1'b1, 1'b1);
    wr_pixel = 8'hA5; write_en_sdram = 1'b1;
    tick();
    write_en_sdram = 1'b0; wr_pixel = 8'h00;
    check("wr_req", 32'({mem_req, mem_we, busy, wr_done}), 32'(4'b1110));
    check("wr_addr", 32'(mem_addr), 32'd20);
    check("wr_data", 32'(mem_wdata), 32'hA5);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("wr_done", 32'({wr_done, mem_req, busy}), 32'(3'b100));
    tick();
    check("wr_done_end", 32'(wr_done), 32'(0));

    // Stray ack while idle.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    check("stray_ack", 32'({mem_req, dataRead_sdram, wr_done, busy}), 32'(0));

    // Read/write collision.
    read_en_sdram = 1'b1; write_en_sdram = 1'b1; wr_pixel = 8'h77;
    tick();
    read_en_sdram = 1'b0; write_en_sdram = 1'b0;
    check("coll_req", 32'({mem_req, mem_we, overrun_err}), 32'(3'b101));
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    tick();
    mem_ack = 1'b0;
    tick();
    check("coll_read", 32'({dataRead_sdram, rd_pixel, mem_req}), 32'({1'b1, 8'h5A, 1'b0}));
    tick();
    check("coll_no_write", 32'({mem_req, overrun_err}), 32'(2'b01));
    do_start();
    check("coll_clear", 32'(overrun_err), 32'(0));

    // Read request dropped while a write is in flight.
    wr_pixel = 8'h3E; write_en_sdram = 1'b1;
    tick();
    write_en_sdram = 1'b0;
    read_en_sdram = 1'b1;
    tick();
    read_en_sdram = 1'b0;
    check("drop_busy", 32'({mem_req, mem_we, overrun_err}), 32'(3'b111));
    check("drop_data", 32'(mem_wdata), 32'h3E);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("drop_wr_done", 32'({wr_done, mem_req}), 32'(2'b10));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("drop_no_req", 32'({mem_req, dataRead_sdram, overrun_err}), 32'(3'b001));
    end
    do_start();

    // Randomized transactions against the reference model.
    for (int t = 0; t < 40; t++) rand_txn();
    check("rand_no_overrun", 32'(overrun_err), 32'(0));

    // Reset in the middle of a read request.
    pulse(1'b0, 1'b0, 1'b0);
    while (mi != IMG_W - 1) pulse(1'b1, 1'b0, 1'b0);
    while (mj != IMG_H - 2) pulse(1'b0, 1'b1, 1'b0);
    check_rol("pre_reset_rollover");
    read_en_sdram = 1'b1;
    tick();
    read_en_sdram = 1'b0;
    check("pre_reset_req", 32'({mem_req, busy}), 32'(2'b11));
    rst = 1'b1;
    tick();
    check("rst_abandon", 32'({mem_req, busy, mem_we}), 32'(0));
    check("rst_counters", 32'({rollover_i, rollover_j, rollover_i_wr}), 32'(0));
    tick();
    rst = 1'b0;
    model_clear();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    check("post_reset_idle", 32'({mem_req, dataRead_sdram, busy}), 32'(0));
    pulse(1'b1, 1'b1, 1'b1);
    check_rol("post_reset_count");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
